// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions for the register file slice.
//   - DEFAULT_N / DEFAULT_NREG : default data width and register count
//   - dump_state_t             : dump sequencer states (IDLE, SEND)
//   - addr_width()             : register-index width for a given count
package picomips_pkg;

  localparam int DEFAULT_N    = 8;
  localparam int DEFAULT_NREG = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

  // Index width for nreg registers; never narrower than one bit.
  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regs_dump_fsm.sv
// Dump sequencer for the register file. Walks addresses 0..NREG-1 with a
// valid/ready handshake and tells the storage array when to capture the
// next word.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   dump_start        : one-cycle pulse, honoured only in IDLE
//   dump_ready        : consumer accepts the current word
//   dump_busy         : sequencer is in SEND
//   dump_valid        : dump_addr / snapshot data are valid
//   dump_addr         : index of the word currently presented
//   rd_addr           : register to capture when snap is high
//   snap              : capture strobe for the snapshot register
module regs_dump_fsm
  import picomips_pkg::*;
#(
  parameter int NREG = DEFAULT_NREG,
  parameter int AW   = addr_width(DEFAULT_NREG)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          dump_start,
  input  logic          dump_ready,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [AW-1:0] rd_addr,
  output logic          snap
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  dump_state_t   state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rd_addr    = addr_reg;
    snap       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dump_start) begin
          state_next = SEND;
          addr_next  = '0;
          rd_addr    = '0;
          snap       = 1'b1;
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (addr_reg == LAST_ADDR) begin
            state_next = IDLE;
          end else begin
            // Capture the following register on the same edge as the
            // transfer, so the word presented next is its pre-edge value.
            addr_next = addr_reg + AW'(1);
            rd_addr   = addr_reg + AW'(1);
            snap      = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dump_busy  = (state_reg == SEND);
  assign dump_valid = (state_reg == SEND);
  assign dump_addr  = addr_reg;

endmodule

// File: rtl/regs_param.sv
// Parametrised picoMIPS register file: NREG x n bits, %0 hard-wired to zero,
// two combinational read ports, one processor write port, a handshaked
// external load port and a register dump streamer.
// Optional build macro: REGS_BYPASS_EN -- same-cycle forwarding of the
// processor write (first) or an accepted load (second) to reads and to
// dump snapshots.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   w, Wdata               : processor write to register Raddr2
//   Raddr1/Raddr2          : read addresses; Rdata1/Rdata2 read data
//   ld_valid/addr/data     : external load request; ld_ready = accepted
//   dump_start, dump_ready : start pulse and consumer handshake
//   dump_busy/valid/addr/data : dump stream outputs
module regs_param
  import picomips_pkg::*;
#(
  parameter  int n    = DEFAULT_N,
  parameter  int NREG = DEFAULT_NREG,
  localparam int AW   = addr_width(NREG)
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                w,
  input  logic [n-1:0]        Wdata,
  input  logic [AW-1:0]       Raddr1,
  input  logic [AW-1:0]       Raddr2,
  output logic signed [n-1:0] Rdata1,
  output logic signed [n-1:0] Rdata2,
  input  logic                ld_valid,
  input  logic [AW-1:0]       ld_addr,
  input  logic [n-1:0]        ld_data,
  output logic                ld_ready,
  input  logic                dump_start,
  output logic                dump_busy,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_addr,
  output logic [n-1:0]        dump_data
);

  logic [NREG-1:0][n-1:0] gpr;
  logic [AW-1:0]          snap_addr;
  logic                   snap;
  logic [n-1:0]           snap_data;
  logic [n-1:0]           dump_data_reg;

  // A load only loses when it targets the very register the processor is
  // writing; writes to %0 are dropped anyway, so they never block a load.
  assign ld_ready = ld_valid && !(w && (ld_addr == Raddr2) && (ld_addr != '0));

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign gpr[gi] = '0;
      end else begin : g_store
        logic [n-1:0] q_reg;
        logic         we_proc;
        logic         we_ld;
        assign we_proc = w && (Raddr2 == AW'(gi));
        assign we_ld   = ld_ready && (ld_addr == AW'(gi));
        // we_proc and we_ld are never both set for the same register.
        always_ff @(posedge clk) begin
          if (reset) begin
            q_reg <= '0;
          end else if (we_proc) begin
            q_reg <= Wdata;
          end else if (we_ld) begin
            q_reg <= ld_data;
          end
        end
        assign gpr[gi] = q_reg;
      end
    end
  endgenerate

  function automatic logic [n-1:0] rd(input logic [AW-1:0] a);
    logic [n-1:0] v;
    v = gpr[a];
`ifdef REGS_BYPASS_EN
    if (ld_ready && (ld_addr == a)) v = ld_data;
    if (w && (Raddr2 == a)) v = Wdata;
`endif
    if (a == '0) v = '0;
    return v;
  endfunction

  assign Rdata1    = rd(Raddr1);
  assign Rdata2    = rd(Raddr2);
  assign snap_data = rd(snap_addr);

  regs_dump_fsm #(
    .NREG (NREG),
    .AW   (AW)
  ) u_dump (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .rd_addr    (snap_addr),
    .snap       (snap)
  );

  // Snapshot holds while the consumer stalls, even if the register changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      dump_data_reg <= '0;
    end else if (snap) begin
      dump_data_reg <= snap_data;
    end
  end

  assign dump_data = dump_data_reg;

endmodule
